// File: rtl/pw_feature_streamer.sv
// pw_feature_streamer: reads a FEATURE_SIZE x FEATURE_SIZE x IN_CHANNELS feature map
// from a 1-cycle-latency buffer and streams it, pixel-major then channel, as a
// data/channel/valid beat stream with ready backpressure.
// Optional build macro PW_STREAM_LAST_EN adds last_out (high on each pixel's final channel).
// mem_rd_en is a combinational decode of state and FIFO occupancy (including this
// cycle's pop), so a slot freed this cycle can be refilled and sustain one beat per cycle.
module pw_feature_streamer #(
   parameter int unsigned N            = 16,
   parameter int unsigned IN_CHANNELS  = 40,
   parameter int unsigned FEATURE_SIZE = 14,
   localparam int unsigned ADDR_W      = $clog2(FEATURE_SIZE*FEATURE_SIZE*IN_CHANNELS),
   localparam int unsigned CH_W        = $clog2(IN_CHANNELS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [N-1:0]      mem_rdata,
   output logic [N-1:0]      data_out,
   output logic [CH_W-1:0]   channel_out,
   output logic              valid_out,
`ifdef PW_STREAM_LAST_EN
   output logic              last_out,
`endif
   input  logic              ready_in,
   output logic              busy,
   output logic              done
);

   localparam int unsigned NPIX  = FEATURE_SIZE * FEATURE_SIZE;
   localparam int unsigned TOTAL = NPIX * IN_CHANNELS;
   localparam int unsigned PIX_W = (NPIX > 1) ? $clog2(NPIX) : 1;

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_e;

   state_e state_q, state_d;

   // read-side counters
   logic [PIX_W-1:0]  pix_q, pix_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] beat_q, beat_d;

   // read in flight (data returns next cycle) with its tag
   logic              rvalid_q, rvalid_d;
   logic [CH_W-1:0]   rtag_ch_q, rtag_ch_d;

   // 2-entry FIFO: head entry doubles as the registered output
   logic [N-1:0]      head_data_q, head_data_d;
   logic [CH_W-1:0]   head_ch_q, head_ch_d;
   logic              head_vld_q, head_vld_d;
   logic [N-1:0]      sk_data_q, sk_data_d;
   logic [CH_W-1:0]   sk_ch_q, sk_ch_d;
   logic              sk_vld_q, sk_vld_d;
`ifdef PW_STREAM_LAST_EN
   logic              rtag_last_q, rtag_last_d;
   logic              head_last_q, head_last_d;
   logic              sk_last_q, sk_last_d;
`endif

   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              pop_c;
   logic              start_ok_c;
   logic              last_rd_c;
   logic              last_beat_c;
   logic [1:0]        occ_c;
   logic              rd_en_c;

   // handshake, occupancy and read-issue decode
   always_comb begin
      pop_c       = head_vld_q & ready_in;
      start_ok_c  = start & ((state_q == S_IDLE) | (state_q == S_DONE));
      last_rd_c   = (pix_q == PIX_W'(NPIX - 1)) & (ch_q == CH_W'(IN_CHANNELS - 1));
      last_beat_c = (beat_q == ADDR_W'(TOTAL - 1));
      occ_c       = 2'(head_vld_q) + 2'(sk_vld_q) + 2'(rvalid_q) - 2'(pop_c);
      rd_en_c     = (state_q == S_STREAM) & (occ_c < 2'd2);
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_DONE: if (start) state_d = S_STREAM;
         S_STREAM:       if (rd_en_c && last_rd_c) state_d = S_DRAIN;
         S_DRAIN:        if (pop_c && last_beat_c) state_d = S_DONE;
         default:        state_d = S_IDLE;
      endcase
   end

   // counters, read pipeline, FIFO and status next-values
   always_comb begin
      pix_d       = pix_q;
      ch_d        = ch_q;
      addr_d      = addr_q;
      beat_d      = beat_q;
      rvalid_d    = rd_en_c;
      rtag_ch_d   = rtag_ch_q;
      head_data_d = head_data_q;
      head_ch_d   = head_ch_q;
      head_vld_d  = head_vld_q;
      sk_data_d   = sk_data_q;
      sk_ch_d     = sk_ch_q;
      sk_vld_d    = sk_vld_q;
`ifdef PW_STREAM_LAST_EN
      rtag_last_d = rtag_last_q;
      head_last_d = head_last_q;
      sk_last_d   = sk_last_q;
`endif
      busy_d      = (state_d == S_STREAM) | (state_d == S_DRAIN);
      done_d      = (state_d == S_DONE);

      // address walks linearly; channel/pixel counters only track position
      if (start_ok_c) begin
         pix_d  = '0;
         ch_d   = '0;
         addr_d = '0;
         beat_d = '0;
      end else begin
         if (rd_en_c && !last_rd_c) begin
            addr_d = addr_q + ADDR_W'(1);
            if (ch_q == CH_W'(IN_CHANNELS - 1)) begin
               ch_d  = '0;
               pix_d = pix_q + PIX_W'(1);
            end else begin
               ch_d  = ch_q + CH_W'(1);
            end
         end
         if (pop_c && !last_beat_c) beat_d = beat_q + ADDR_W'(1);
      end

      if (rd_en_c) begin
         rtag_ch_d   = ch_q;
`ifdef PW_STREAM_LAST_EN
         rtag_last_d = (ch_q == CH_W'(IN_CHANNELS - 1));
`endif
      end

      // FIFO: returning read data is the write; head is only replaced on pop or when empty
      if (pop_c) begin
         if (sk_vld_q) begin
            head_data_d = sk_data_q;
            head_ch_d   = sk_ch_q;
`ifdef PW_STREAM_LAST_EN
            head_last_d = sk_last_q;
`endif
            sk_vld_d    = rvalid_q;
            if (rvalid_q) begin
               sk_data_d = mem_rdata;
               sk_ch_d   = rtag_ch_q;
`ifdef PW_STREAM_LAST_EN
               sk_last_d = rtag_last_q;
`endif
            end
         end else if (rvalid_q) begin
            head_data_d = mem_rdata;
            head_ch_d   = rtag_ch_q;
`ifdef PW_STREAM_LAST_EN
            head_last_d = rtag_last_q;
`endif
         end else begin
            head_vld_d  = 1'b0;
         end
      end else if (rvalid_q) begin
         if (!head_vld_q) begin
            head_data_d = mem_rdata;
            head_ch_d   = rtag_ch_q;
            head_vld_d  = 1'b1;
`ifdef PW_STREAM_LAST_EN
            head_last_d = rtag_last_q;
`endif
         end else begin
            sk_data_d   = mem_rdata;
            sk_ch_d     = rtag_ch_q;
            sk_vld_d    = 1'b1;
`ifdef PW_STREAM_LAST_EN
            sk_last_d   = rtag_last_q;
`endif
         end
      end
   end

   // datapath and status registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_q       <= '0;
         ch_q        <= '0;
         addr_q      <= '0;
         beat_q      <= '0;
         rvalid_q    <= 1'b0;
         rtag_ch_q   <= '0;
         head_data_q <= '0;
         head_ch_q   <= '0;
         head_vld_q  <= 1'b0;
         sk_data_q   <= '0;
         sk_ch_q     <= '0;
         sk_vld_q    <= 1'b0;
`ifdef PW_STREAM_LAST_EN
         rtag_last_q <= 1'b0;
         head_last_q <= 1'b0;
         sk_last_q   <= 1'b0;
`endif
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         pix_q       <= pix_d;
         ch_q        <= ch_d;
         addr_q      <= addr_d;
         beat_q      <= beat_d;
         rvalid_q    <= rvalid_d;
         rtag_ch_q   <= rtag_ch_d;
         head_data_q <= head_data_d;
         head_ch_q   <= head_ch_d;
         head_vld_q  <= head_vld_d;
         sk_data_q   <= sk_data_d;
         sk_ch_q     <= sk_ch_d;
         sk_vld_q    <= sk_vld_d;
`ifdef PW_STREAM_LAST_EN
         rtag_last_q <= rtag_last_d;
         head_last_q <= head_last_d;
         sk_last_q   <= sk_last_d;
`endif
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign mem_rd_en   = rd_en_c;
   assign mem_addr    = addr_q;
   assign data_out    = head_data_q;
   assign channel_out = head_ch_q;
   assign valid_out   = head_vld_q;
`ifdef PW_STREAM_LAST_EN
   assign last_out    = head_last_q;
`endif
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

// File: tb/tb_pw_feature_streamer.sv
// Bench for pw_feature_streamer: 2x2x4 map (16 beats), buffer model mem[a] = a + 0x0100.
// Expected beat k: data 0x0100+k, channel k%4, last on k%4==3 (when PW_STREAM_LAST_EN).
module tb_pw_feature_streamer;

   localparam int unsigned IC    = 4;
   localparam int unsigned FS    = 2;
   localparam int unsigned TOTAL = FS * FS * IC;
   localparam int unsigned AW    = $clog2(TOTAL);
   localparam int unsigned CW    = $clog2(IC);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic [15:0]   mem_rdata = 16'h0;
   logic [15:0]   data_out;
   logic [CW-1:0] channel_out;
   logic          valid_out;
   logic          ready_in;
   logic          busy;
   logic          done;
`ifdef PW_STREAM_LAST_EN
   logic          last_out;
`endif

   int n_cmp = 0;
   int n_err = 0;

   pw_feature_streamer #(.N(16), .IN_CHANNELS(IC), .FEATURE_SIZE(FS)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .data_out(data_out), .channel_out(channel_out), .valid_out(valid_out),
`ifdef PW_STREAM_LAST_EN
      .last_out(last_out),
`endif
      .ready_in(ready_in), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // 1-cycle-latency buffer
   always @(posedge clk) if (mem_rd_en) mem_rdata <= 16'h0100 + 16'(mem_addr);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_rd_en"}, 32'(mem_rd_en), 0);
      check({tag, "_addr"},  32'(mem_addr),  0);
      check({tag, "_data"},  32'(data_out),  0);
      check({tag, "_ch"},    32'(channel_out), 0);
      check({tag, "_valid"}, 32'(valid_out), 0);
      check({tag, "_busy"},  32'(busy), 0);
      check({tag, "_done"},  32'(done), 0);
`ifdef PW_STREAM_LAST_EN
      check({tag, "_last"},  32'(last_out), 0);
`endif
   endtask

   // mode: 0 ready=1, 1 toggling, 2 random, 3 stall 5 cycles on beat 6, 4 ready=1 with stray start at beat 5
   task automatic run_frame(input int mode);
      int  c, beats, rd_exp, stall;
      bit  fin;
      @(negedge clk);
      start = 1'b1; ready_in = 1'b0;
      c = 0; beats = 0; rd_exp = 0; stall = 0; fin = 1'b0;
      while (!fin && c < 300) begin
         @(negedge clk);
         c++;
         start = 1'b0;
         case (mode)
            1:       ready_in = (c % 2 == 1);
            2:       ready_in = 1'($urandom_range(0, 1));
            3: begin
               if (valid_out && beats == 6 && stall < 5) begin ready_in = 1'b0; stall++; end
               else ready_in = 1'b1;
            end
            default: ready_in = 1'b1;
         endcase
         if (mode == 4 && valid_out && beats == 5) start = 1'b1;
         #1;
         if (beats == int'(TOTAL)) begin
            check("end_done",  32'(done), 1);
            check("end_busy",  32'(busy), 0);
            check("end_valid", 32'(valid_out), 0);
            check("end_rd_en", 32'(mem_rd_en), 0);
            fin = 1'b1;
         end else begin
            check("busy_hi", 32'(busy), 1);
            check("done_lo", 32'(done), 0);
            if (c == 1) check("rd_latency", 32'(mem_rd_en), 1);
            if ((mode == 0 || mode == 4) && c < 3) check("valid_early", 32'(valid_out), 0);
            if (mode == 3 && valid_out && !ready_in) begin
               check("stall_data", 32'(data_out), 32'h0106);
               check("stall_ch",   32'(channel_out), 2);
            end
            if (mem_rd_en) begin
               check("rd_addr",  32'(mem_addr), 32'(rd_exp));
               check("rd_bound", 32'(mem_addr <= AW'(beats + 2)), 1);
               rd_exp++;
            end
            if (valid_out && ready_in) begin
               check("beat_data", 32'(data_out), 32'h0100 + 32'(beats));
               check("beat_ch",   32'(channel_out), 32'(beats % int'(IC)));
`ifdef PW_STREAM_LAST_EN
               check("beat_last", 32'(last_out), 32'(beats % int'(IC) == int'(IC) - 1));
`endif
               if (mode == 0 || mode == 4) check("beat_cycle", 32'(c), 32'(3 + beats));
               beats++;
            end
         end
      end
      if (!fin) check("frame_timeout", 0, 1);
      check("reads_total", 32'(rd_exp), 32'(TOTAL));
      ready_in = 1'b0;
   endtask

   initial begin
      int k;
      // reset
      rst_n = 1'b0; start = 1'b0; ready_in = 1'b0;
      #1;
      check_zero("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) begin
         @(negedge clk); #1;
         check("idle_rd_en", 32'(mem_rd_en), 0);
         check("idle_valid", 32'(valid_out), 0);
      end

      // full stream, backpressure, stray start, restart after done
      run_frame(0);
      run_frame(1);
      run_frame(3);
      run_frame(4);
      run_frame(2);
      run_frame(2);

      // reset mid-frame at beat 7
      @(negedge clk);
      start = 1'b1; ready_in = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!(valid_out && data_out == 16'h0107) && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("mid_beat7", 32'(data_out), 32'h0107);
      rst_n = 1'b0;
      #1;
      check_zero("mid_reset");
      ready_in = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk); #1;
         check("post_rst_done",  32'(done), 0);
         check("post_rst_busy",  32'(busy), 0);
         check("post_rst_rd_en", 32'(mem_rd_en), 0);
      end
      run_frame(0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
